// File: rtl/imem_loader_if.sv
// Byte-stream handshake feeding the IMEM loader (UART RX / debug host side).
interface imem_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    // Stream source: drives bytes, observes backpressure.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    // Stream sink: the loader.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/imem_loader.sv
// IMEM loader: takes a little-endian program image from a byte stream
// (16-bit word-count header, then words) and writes it into the IMEM write
// port, holding the core in reset until the whole image has landed.
module imem_loader #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    imem_loader_if.slave       stream,
    output logic               wr_en,
    output logic [31:0]        wr_addr,
    output logic [31:0]        wr_data,
    output logic [CNT_W-1:0]   word_count,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               cpu_rst_n
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HDR_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]    word_idx_q, word_idx_d;
    logic [23:0]         buf_q, buf_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;

    logic                xfer_c;
    logic [HDR_W-1:0]    hdr_c;

    // A byte is consumed only when the registered ready is high.
    assign xfer_c = stream.in_valid & in_ready_q;
    // Full header as it would be once the high byte is taken this cycle.
    assign hdr_c  = {stream.in_data, n_q[7:0]};

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        buf_d        = buf_q;
        in_ready_d   = in_ready_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        cpu_rst_n_d  = cpu_rst_n_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_CNT_LO;
                    in_ready_d   = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    cpu_rst_n_d  = 1'b0;
                    word_count_d = '0;
                end
            end

            S_CNT_LO: begin
                if (xfer_c) begin
                    n_d     = CNT_W'(stream.in_data);
                    state_d = S_CNT_HI;
                end
            end

            S_CNT_HI: begin
                if (xfer_c) begin
                    n_d = CNT_W'(hdr_c);
                    if (hdr_c == '0 || 32'(hdr_c) > DEPTH) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d    = S_DATA;
                        byte_idx_d = '0;
                        word_idx_d = '0;
                    end
                end
            end

            S_DATA: begin
                if (xfer_c) begin
                    if (byte_idx_q == 2'd3) begin
                        // Fourth byte completes the word: issue the write.
                        wr_en_d      = 1'b1;
                        wr_addr_d    = ADDR_W'({word_idx_q, 2'b00});
                        wr_data_d    = {stream.in_data, buf_q};
                        word_count_d = word_count_q + CNT_W'(1);
                        word_idx_d   = word_idx_q + CNT_W'(1);
                        byte_idx_d   = '0;
                        if (word_idx_q == n_q - CNT_W'(1)) begin
                            state_d     = S_DONE;
                            done_d      = 1'b1;
                            busy_d      = 1'b0;
                            in_ready_d  = 1'b0;
                            cpu_rst_n_d = 1'b1;
                        end
                    end else begin
                        case (byte_idx_q)
                            2'd0:    buf_d[7:0]   = stream.in_data;
                            2'd1:    buf_d[15:8]  = stream.in_data;
                            default: buf_d[23:16] = stream.in_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            buf_q        <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            buf_q        <= buf_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
        end
    end

    assign stream.in_ready = in_ready_q;
    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign word_count      = word_count_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign cpu_rst_n       = cpu_rst_n_q;

endmodule
